// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display: blanked digit slots,
// per-slot BCD latch and decode, frame-based blinking. All outputs registered.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  selector,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  scan_idx,
  output logic        frame_tick
);

  localparam int SHOW_CYC = SCAN_DIV - BLANK_CYC;
  localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W    = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         idx_r, idx_s;
  logic [FRM_W-1:0]   frame_cnt_r, frame_cnt_s;
  logic               blink_phase_r, blink_phase_s;
  logic [3:0]         lat_nib_r, lat_nib_s;
  logic               lat_dp_r, lat_dp_s;
  logic               lat_blink_r, lat_blink_s;
  logic               wrap_s;
  logic [3:0]         selector_r, selector_s;
  logic [6:0]         seg_r, seg_s;
  logic               dp_r, dp_s;
  logic               frame_tick_r;

  // Active-low segment pattern {a,b,c,d,e,f,g}; codes 10-15 render blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h01;
      4'd1:    pat = 7'h4F;
      4'd2:    pat = 7'h12;
      4'd3:    pat = 7'h06;
      4'd4:    pat = 7'h4C;
      4'd5:    pat = 7'h24;
      4'd6:    pat = 7'h20;
      4'd7:    pat = 7'h0F;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h04;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Next-state: slot sequencing, digit latch, frame/blink bookkeeping.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    frame_cnt_s   = frame_cnt_r;
    blink_phase_s = blink_phase_r;
    lat_nib_s     = lat_nib_r;
    lat_dp_s      = lat_dp_r;
    lat_blink_s   = lat_blink_r;
    wrap_s        = 1'b0;
    if (!enable) begin
      state_s       = ST_BLANK;
      cnt_s         = '0;
      idx_s         = 2'd0;
      frame_cnt_s   = '0;
      blink_phase_s = 1'b0;
    end else begin
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == CNT_W'(BLANK_CYC - 1)) begin
            state_s     = ST_SHOW;
            cnt_s       = '0;
            lat_nib_s   = digits_bcd[{idx_r, 2'b00} +: 4];
            lat_dp_s    = dp_mask[idx_r];
            lat_blink_s = blink_mask[idx_r];
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == CNT_W'(SHOW_CYC - 1)) begin
            state_s = ST_BLANK;
            cnt_s   = '0;
            idx_s   = idx_r + 2'd1;
            wrap_s  = (idx_r == 2'd3);
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = ST_BLANK;
          cnt_s   = '0;
        end
      endcase
      // A wrap and a blink toggle may coincide; both apply on the same edge.
      if (wrap_s) begin
        if (frame_cnt_r == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_s   = '0;
          blink_phase_s = ~blink_phase_r;
        end else begin
          frame_cnt_s = frame_cnt_r + FRM_W'(1);
        end
      end else begin
        frame_cnt_s = frame_cnt_r;
      end
    end
  end

  // Output pre-decode from next-state so the pins change on the same edge as the state.
  always_comb begin
    selector_s = 4'b1111;
    seg_s      = 7'h7F;
    dp_s       = 1'b1;
    if (state_s == ST_SHOW) begin
      selector_s = ~(4'b0001 << idx_s);
      if (blink_phase_s && lat_blink_s) begin
        seg_s = 7'h7F;
        dp_s  = 1'b1;
      end else begin
        seg_s = bcd_to_seg(lat_nib_s);
        dp_s  = ~lat_dp_s;
      end
    end else begin
      selector_s = 4'b1111;
    end
  end

  // State, latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BLANK;
      cnt_r         <= '0;
      idx_r         <= 2'd0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      lat_nib_r     <= 4'd0;
      lat_dp_r      <= 1'b0;
      lat_blink_r   <= 1'b0;
      selector_r    <= 4'b1111;
      seg_r         <= 7'h7F;
      dp_r          <= 1'b1;
      frame_tick_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      frame_cnt_r   <= frame_cnt_s;
      blink_phase_r <= blink_phase_s;
      lat_nib_r     <= lat_nib_s;
      lat_dp_r      <= lat_dp_s;
      lat_blink_r   <= lat_blink_s;
      selector_r    <= selector_s;
      seg_r         <= seg_s;
      dp_r          <= dp_s;
      frame_tick_r  <= wrap_s;
    end
  end

  assign selector   = selector_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign scan_idx   = idx_r;
  assign frame_tick = frame_tick_r;

endmodule
